i2c_ahb_master_bridge: RTL and testbench
========================================

Name: i2c_ahb_master_bridge

Overview:
- Downstream stage of the I2C AHB-slave front end. Takes its single-cycle write and read request pulses (32-bit address, 32-bit write data) and performs single-word AHB-Lite master transfers.
- Returns read data with a completion pulse, which the front end loads into its read mailbox.
- Owns all bus timing: wait states, error responses and timeouts. The I2C side never sees HREADY.

Parameters:
- TIMEOUT_CYC, 255, max consecutive hready_i=0 cycles in ADDR or DATA before abort; 0 disables timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- w_valid_i  in  1  write request pulse
- waddr_i  in  32  write address, sampled with w_valid_i
- wdata_i  in  32  write data, sampled with w_valid_i
- r_valid_i  in  1  read request pulse
- raddr_i  in  32  read address, sampled with r_valid_i
- rdata_o  out  32  last good read data, held until next good read
- rd_done_o  out  1  one-cycle pulse when rdata_o is updated
- wr_done_o  out  1  one-cycle pulse on good write completion
- err_vld_o  out  1  one-cycle pulse on aborted/failed request
- err_code_o  out  2  01 HRESP error, 10 timeout, 11 misaligned; held until next error
- overrun_o  out  1  one-cycle pulse when a pending request is overwritten
- busy_o  out  1  high when in ADDR/DATA or any request is pending
- haddr_o  out  32  AHB address
- htrans_o  out  2  IDLE=00, NONSEQ=10 only
- hwrite_o  out  1  AHB direction
- hsize_o  out  3  constant 3'b010 (word)
- hburst_o  out  3  constant 3'b000 (SINGLE)
- hwdata_o  out  32  write data, driven during data phase
- hrdata_i  in  32  AHB read data
- hready_i  in  1  AHB ready
- hresp_i  in  1  AHB response, 1 = ERROR

Behaviour:
- Reset (async, rst_i=1): state IDLE, pending slots cleared.
  - All outputs 0, except hsize_o=010 and hburst_o=000.
  - rdata_o=0, err_code_o=00.
- Request capture, every cycle regardless of state:
  - w_valid_i=1 loads the write slot {waddr,wdata} and sets wr_pend.
  - r_valid_i=1 loads the read slot and sets rd_pend.
  - Both asserted in the same cycle: both captured.
  - A pulse arriving while its slot is already pending (not yet issued) overwrites the slot (latest wins) and pulses overrun_o.
  - A slot clears when its request is issued. A new pulse in the issue cycle is captured as a fresh pending request with no overrun.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: if wr_pend, issue the write; else if rd_pend, issue the read (write has priority).
    - Issue with misaligned address (addr[1:0]!=0): no bus activity; clear the slot; err_vld_o=1, err_code_o=11; stay IDLE.
    - Issue with aligned address: register haddr_o, hwrite_o, htrans_o=NONSEQ; go to ADDR.
  - ADDR: hold haddr/hwrite/NONSEQ while hready_i=0. On hready_i=1: htrans_o=IDLE, hwdata_o=write data (writes), go to DATA.
  - DATA: hold hwdata_o while hready_i=0.
    - hready_i=1, hresp_i=0: a read loads rdata_o=hrdata_i and pulses rd_done_o; a write pulses wr_done_o. Go to IDLE.
    - hready_i=1, hresp_i=1: err_vld_o=1, err_code_o=01; rdata_o unchanged; go to IDLE.
    - hresp_i=1 with hready_i=0 (first error cycle): wait. htrans is already IDLE.
- Latency:
  - Request pulse in cycle N → pending in N+1 → NONSEQ in N+2.
  - Zero-wait slave: data phase in N+3; done pulse and rdata_o valid in N+4.
  - Each wait state adds 1 cycle.
  - Back-to-back: the next request's NONSEQ appears the cycle after return to IDLE (no pipelined address phase).
- Timeout:
  - Counter clears on entering ADDR and on each hready_i=1; increments on hready_i=0 in ADDR/DATA.
  - On reaching TIMEOUT_CYC: htrans_o=IDLE, err_vld_o=1, err_code_o=10, go to IDLE, request dropped.
- busy_o = (state!=IDLE) | wr_pend | rd_pend, registered.
- Reset mid-transfer: immediate return to reset values. No completion or error pulse; pending requests lost.

Test Plan:
- Zero-wait write 0x4000_0010/0xDEAD_BEEF: NONSEQ at N+2 with hwrite=1, hwdata=DEADBEEF at N+3, wr_done_o at N+4; rdata_o unchanged.
- Read 0x4000_0020 with 2 wait states in data phase, hrdata=0x1234_5678: rdata_o=0x12345678 and rd_done_o at N+6.
- w_valid_i and r_valid_i same cycle: write transfer completes first, then read NONSEQ the cycle after IDLE; no overrun_o.
- Two writes while first pending, then HRESP ERROR on the surviving second: overrun_o pulses once; second address on bus; err_vld_o with err_code_o=01.
- TIMEOUT_CYC=4, hready_i held 0 in ADDR: err_vld_o after 4 stall cycles, err_code_o=10, htrans_o=00, busy_o drops.
- Read to 0x4000_0002: no NONSEQ ever driven, err_code_o=11. Then a read with rst_i asserted during DATA: all outputs return to reset values, no rd_done_o.

Source files
------------

// File: rtl/i2c_ahb_master_bridge.sv
// Single-word AHB-Lite master fed by write/read request pulses from the I2C front end.
// Holds one pending write and one pending read; owns wait states, error responses and timeouts.
module i2c_ahb_master_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_valid_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        r_valid_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic        rd_done_o,
  output logic        wr_done_o,
  output logic        err_vld_o,
  output logic [1:0]  err_code_o,
  output logic        overrun_o,
  output logic        busy_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  localparam logic [1:0] E_HRESP = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_ALIGN = 2'b11;

  localparam logic             TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [31:0]      wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic [31:0]      cur_wdata_q, cur_wdata_d;
  logic [31:0]      haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic [1:0]       htrans_q, htrans_d, err_code_q, err_code_d;
  logic             hwrite_q, hwrite_d;
  logic             rd_done_q, rd_done_d, wr_done_q, wr_done_d, err_vld_q, err_vld_d;
  logic             overrun_q, overrun_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_wr, issue_rd, tmo_hit;

  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    cur_wdata_d = cur_wdata_q;
    rdata_d     = rdata_q;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    err_vld_d   = 1'b0;
    issue_wr    = 1'b0;
    issue_rd    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_pend_q) begin
          issue_wr = 1'b1;
          if (wr_addr_q[1:0] != 2'b00) begin
            err_vld_d  = 1'b1;
            err_code_d = E_ALIGN;
          end else begin
            haddr_d     = wr_addr_q;
            hwrite_d    = 1'b1;
            htrans_d    = HT_NONSEQ;
            cur_wdata_d = wr_data_q;
            cnt_d       = '0;
            state_d     = S_ADDR;
          end
        end else if (rd_pend_q) begin
          issue_rd = 1'b1;
          if (rd_addr_q[1:0] != 2'b00) begin
            err_vld_d  = 1'b1;
            err_code_d = E_ALIGN;
          end else begin
            haddr_d  = rd_addr_q;
            hwrite_d = 1'b0;
            htrans_d = HT_NONSEQ;
            cnt_d    = '0;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (hready_i) begin
          htrans_d = HT_IDLE;
          cnt_d    = '0;
          if (hwrite_q) hwdata_d = cur_wdata_q;
          state_d  = S_DATA;
        end else if (tmo_hit) begin
          htrans_d   = HT_IDLE;
          err_vld_d  = 1'b1;
          err_code_d = E_TMO;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (hready_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (hresp_i) begin
            err_vld_d  = 1'b1;
            err_code_d = E_HRESP;
          end else if (hwrite_q) begin
            wr_done_d = 1'b1;
          end else begin
            rd_done_d = 1'b1;
            rdata_d   = hrdata_i;
          end
        end else if (tmo_hit) begin
          err_vld_d  = 1'b1;
          err_code_d = E_TMO;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pulse in the issue cycle refills the freed slot, so it is not an overrun.
  always_comb begin
    wr_addr_d = w_valid_i ? waddr_i : wr_addr_q;
    wr_data_d = w_valid_i ? wdata_i : wr_data_q;
    rd_addr_d = r_valid_i ? raddr_i : rd_addr_q;
    wr_pend_d = w_valid_i | (wr_pend_q & ~issue_wr);
    rd_pend_d = r_valid_i | (rd_pend_q & ~issue_rd);
    overrun_d = (w_valid_i & wr_pend_q & ~issue_wr) | (r_valid_i & rd_pend_q & ~issue_rd);
    busy_d    = (state_d != S_IDLE) | wr_pend_d | rd_pend_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      cur_wdata_q <= '0;
      haddr_q     <= '0;
      htrans_q    <= HT_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rdata_q     <= '0;
      err_code_q  <= 2'b00;
      cnt_q       <= '0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      err_vld_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      cur_wdata_q <= cur_wdata_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      rdata_q     <= rdata_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      err_vld_q   <= err_vld_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rd_done_o  = rd_done_q;
  assign wr_done_o  = wr_done_q;
  assign err_vld_o  = err_vld_q;
  assign err_code_o = err_code_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = busy_q;
  assign haddr_o    = haddr_q;
  assign htrans_o   = htrans_q;
  assign hwrite_o   = hwrite_q;
  assign hsize_o    = 3'b010;
  assign hburst_o   = 3'b000;
  assign hwdata_o   = hwdata_q;

endmodule

// File: tb/tb_i2c_ahb_master_bridge.sv
// Directed bench for i2c_ahb_master_bridge: a small AHB slave model, directed requests,
// and per-event scoreboard queues checked by an independent monitor.
module tb_i2c_ahb_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_valid_i, r_valid_i;
  logic [31:0] waddr_i, wdata_i, raddr_i;
  logic [31:0] rdata_o;
  logic        rd_done_o, wr_done_o, err_vld_o, overrun_o, busy_o;
  logic [1:0]  err_code_o;
  logic [31:0] haddr_o, hwdata_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [31:0] hrdata_i;
  logic        hready_i, hresp_i;

  i2c_ahb_master_bridge #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .w_valid_i(w_valid_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .r_valid_i(r_valid_i), .raddr_i(raddr_i),
    .rdata_o(rdata_o), .rd_done_o(rd_done_o), .wr_done_o(wr_done_o),
    .err_vld_o(err_vld_o), .err_code_o(err_code_o), .overrun_o(overrun_o), .busy_o(busy_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hwdata_o(hwdata_o), .hrdata_i(hrdata_i),
    .hready_i(hready_i), .hresp_i(hresp_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t wrq[$];
  ev_t rdq[$];
  ev_t errq[$];
  ev_t ovq[$];

  // Slave model: configurable data-phase wait states, address-phase stall, error on one address.
  int          ws_cfg = 0;
  int          wcnt = 0;
  bit          addr_stall = 1'b0;
  bit          in_data = 1'b0, enter_d = 1'b0, leave_d = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] rd_val = '0;
  logic [31:0] last_haddr = '0, dat_addr = '0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      in_data  = 1'b0;
      enter_d  = 1'b0;
      leave_d  = 1'b0;
      hready_i = 1'b1;
      hresp_i  = 1'b0;
    end else begin
      if (enter_d) begin
        in_data  = 1'b1;
        wcnt     = 0;
        dat_addr = last_haddr;
      end else if (leave_d) begin
        in_data = 1'b0;
      end
      if (in_data) begin
        hresp_i  = (dat_addr == err_addr);
        hrdata_i = rd_val;
        if (wcnt < ws_cfg) begin
          hready_i = 1'b0;
          wcnt++;
        end else begin
          hready_i = 1'b1;
        end
        leave_d = hready_i;
        enter_d = 1'b0;
      end else begin
        hresp_i    = 1'b0;
        hready_i   = !addr_stall;
        enter_d    = (htrans_o == 2'b10) && hready_i;
        leave_d    = 1'b0;
        last_haddr = haddr_o;
      end
    end
  end

  // Monitor: every completion/error/overrun pulse must match the head of its queue.
  ev_t e;
  always @(negedge clk_i) begin
    if (overrun_o) begin
      if (ovq.size() == 0) chk("overrun unexpected", 32'd1, 32'd0);
      else begin e = ovq.pop_front(); chk("overrun cycle", cyc, e.cyc); end
    end
    if (wr_done_o) begin
      if (wrq.size() == 0) chk("wr_done unexpected", 32'd1, 32'd0);
      else begin e = wrq.pop_front(); chk("wr_done cycle", cyc, e.cyc); end
    end
    if (rd_done_o) begin
      if (rdq.size() == 0) chk("rd_done unexpected", 32'd1, 32'd0);
      else begin
        e = rdq.pop_front();
        chk("rd_done cycle", cyc, e.cyc);
        chk("rdata", rdata_o, e.data);
      end
    end
    if (err_vld_o) begin
      if (errq.size() == 0) chk("err_vld unexpected", 32'd1, 32'd0);
      else begin
        e = errq.pop_front();
        chk("err cycle", cyc, e.cyc);
        chk("err_code", 32'(err_code_o), e.data);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk_i);
      w_valid_i = 1'b0;
      r_valid_i = 1'b0;
    end
  endtask

  task automatic wreq(logic [31:0] a, logic [31:0] d);
    w_valid_i = 1'b1;
    waddr_i   = a;
    wdata_i   = d;
  endtask

  task automatic rreq(logic [31:0] a);
    r_valid_i = 1'b1;
    raddr_i   = a;
  endtask

  task automatic push(int q, logic [31:0] d, int c);
    ev_t x;
    x.data = d;
    x.cyc  = c;
    case (q)
      0: wrq.push_back(x);
      1: rdq.push_back(x);
      2: errq.push_back(x);
      default: ovq.push_back(x);
    endcase
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " htrans"}, 32'(htrans_o), 32'd0);
    chk({tag, " haddr"}, haddr_o, 32'd0);
    chk({tag, " hwrite"}, 32'(hwrite_o), 32'd0);
    chk({tag, " hwdata"}, hwdata_o, 32'd0);
    chk({tag, " hsize"}, 32'(hsize_o), 32'd2);
    chk({tag, " hburst"}, 32'(hburst_o), 32'd0);
    chk({tag, " rdata"}, rdata_o, 32'd0);
    chk({tag, " err_code"}, 32'(err_code_o), 32'd0);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " pulses"}, {28'd0, rd_done_o, wr_done_o, err_vld_o, overrun_o}, 32'd0);
  endtask

  int n;

  initial begin
    rst_i = 1'b1;
    w_valid_i = 1'b0; r_valid_i = 1'b0;
    waddr_i = '0; wdata_i = '0; raddr_i = '0;
    hrdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0;
    @(negedge clk_i);
    chk_reset_vals("reset");
    tick(1);
    rst_i = 1'b0;
    tick(2);

    // Zero-wait write
    n = cyc;
    push(0, 32'd0, n + 4);
    wreq(32'h4000_0010, 32'hDEAD_BEEF);
    tick(1);
    chk("t1 busy", 32'(busy_o), 32'd1);
    chk("t1 htrans early", 32'(htrans_o), 32'd0);
    tick(1);
    chk("t1 htrans", 32'(htrans_o), 32'd2);
    chk("t1 hwrite", 32'(hwrite_o), 32'd1);
    chk("t1 haddr", haddr_o, 32'h4000_0010);
    tick(1);
    chk("t1 data htrans", 32'(htrans_o), 32'd0);
    chk("t1 hwdata", hwdata_o, 32'hDEAD_BEEF);
    tick(1);
    chk("t1 rdata unchanged", rdata_o, 32'd0);
    tick(2);

    // Read with two data-phase wait states
    ws_cfg = 2;
    rd_val = 32'h1234_5678;
    n = cyc;
    push(1, 32'h1234_5678, n + 6);
    rreq(32'h4000_0020);
    tick(2);
    chk("t2 htrans", 32'(htrans_o), 32'd2);
    chk("t2 hwrite", 32'(hwrite_o), 32'd0);
    chk("t2 haddr", haddr_o, 32'h4000_0020);
    tick(5);
    chk("t2 busy idle", 32'(busy_o), 32'd0);
    tick(1);

    // Simultaneous write and read: write first, read NONSEQ the cycle after IDLE
    ws_cfg = 0;
    rd_val = 32'hCAFE_F00D;
    n = cyc;
    push(0, 32'd0, n + 4);
    push(1, 32'hCAFE_F00D, n + 7);
    wreq(32'h4000_0030, 32'hA5A5_A5A5);
    rreq(32'h4000_0034);
    tick(2);
    chk("t3 wr haddr", haddr_o, 32'h4000_0030);
    chk("t3 wr hwrite", 32'(hwrite_o), 32'd1);
    tick(2);
    chk("t3 gap htrans", 32'(htrans_o), 32'd0);
    tick(1);
    chk("t3 rd htrans", 32'(htrans_o), 32'd2);
    chk("t3 rd hwrite", 32'(hwrite_o), 32'd0);
    chk("t3 rd haddr", haddr_o, 32'h4000_0034);
    tick(5);

    // Overrun of a pending write, then HRESP error on the surviving one
    ws_cfg = 3;
    rd_val = 32'h1111_2222;
    err_addr = 32'h4000_0054;
    n = cyc;
    push(1, 32'h1111_2222, n + 7);
    push(3, 32'd0, n + 4);
    push(2, 32'd1, n + 13);
    rreq(32'h4000_0040);
    tick(2);
    wreq(32'h4000_0050, 32'h0000_0001);
    tick(1);
    wreq(32'h4000_0054, 32'h0000_0002);
    tick(5);
    chk("t4 htrans", 32'(htrans_o), 32'd2);
    chk("t4 haddr", haddr_o, 32'h4000_0054);
    chk("t4 hwrite", 32'(hwrite_o), 32'd1);
    tick(1);
    chk("t4 hwdata", hwdata_o, 32'h0000_0002);
    tick(4);
    chk("t4 rdata kept", rdata_o, 32'h1111_2222);
    tick(2);
    err_addr = 32'hFFFF_FFFF;
    ws_cfg = 0;

    // Address-phase timeout after 4 stall cycles
    addr_stall = 1'b1;
    n = cyc;
    push(2, 32'd2, n + 6);
    wreq(32'h4000_0060, 32'h600D_600D);
    tick(5);
    chk("t5 htrans held", 32'(htrans_o), 32'd2);
    tick(1);
    chk("t5 htrans idle", 32'(htrans_o), 32'd0);
    chk("t5 busy", 32'(busy_o), 32'd0);
    addr_stall = 1'b0;
    tick(2);

    // Misaligned read: no bus activity
    n = cyc;
    push(2, 32'd3, n + 2);
    rreq(32'h4000_0002);
    tick(1);
    chk("t6 err_code held", 32'(err_code_o), 32'd2);
    chk("t6 htrans n+1", 32'(htrans_o), 32'd0);
    tick(1);
    chk("t6 htrans n+2", 32'(htrans_o), 32'd0);
    tick(1);
    chk("t6 htrans n+3", 32'(htrans_o), 32'd0);
    chk("t6 busy", 32'(busy_o), 32'd0);
    tick(1);

    // Reset during the data phase of a read
    ws_cfg = 5;
    rd_val = 32'h55AA_55AA;
    rreq(32'h4000_0070);
    tick(4);
    chk("t7 busy before rst", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick(2);
    rst_i = 1'b0;
    tick(12);
    chk("t7 busy after rst", 32'(busy_o), 32'd0);

    chk("wrq drained", 32'(wrq.size()), 32'd0);
    chk("rdq drained", 32'(rdq.size()), 32'd0);
    chk("errq drained", 32'(errq.size()), 32'd0);
    chk("ovq drained", 32'(ovq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
